// File: rtl/tft_text_renderer_pkg.sv
// Shared constants, state encoding and cell addressing for the TFT text renderer
// and any future overlay blocks that reuse its font and buffer geometry.
package tft_text_renderer_pkg;

  localparam int TXT_COLS  = 60;
  localparam int TXT_ROWS  = 17;
  localparam int CELL_W    = 8;
  localparam int CELL_H    = 16;
  localparam int TXT_CELLS = 1020;

  localparam int PIPE_LAT  = 3;

  // Must track the panel driver's timing constants.
  localparam int H_TOTAL   = 526;
  localparam int V_TOTAL   = 289;
  localparam int H_ACTIVE  = 480;
  localparam int V_ACTIVE  = 272;

  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_FF = 8'h0C;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } txt_state_e;

  // row*60 + col without a multiplier: (row<<6) - (row<<2) + col.
  function automatic logic [9:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    logic [10:0] sum;
    sum = {row, 6'b0} - {4'b0, row, 2'b0} + {4'b0, col};
    return sum[9:0];
  endfunction

endpackage

// File: rtl/tft_font_rom.sv
// 2048x8 synchronous glyph ROM addressed by {code[6:0], line[3:0]}, one-cycle read.
// Drawn glyphs: 'A', 'B', 'Z'; space and control codes are blank; other printable codes show a hollow box.
module tft_font_rom (
  input  logic        i_clk,
  input  logic [10:0] i_addr,
  output logic [7:0]  o_data
);

  logic [6:0] w_code;
  logic [3:0] w_line;
  logic [7:0] w_row;
  logic [7:0] r_data;

  assign w_code = i_addr[10:4];
  assign w_line = i_addr[3:0];

  always_comb begin
    w_row = 8'h00;
    case (w_code)
      7'h41: begin
        case (w_line)
          4'd2:                      w_row = 8'h18;
          4'd3:                      w_row = 8'h3C;
          4'd4, 4'd5, 4'd6:          w_row = 8'h66;
          4'd7:                      w_row = 8'h7E;
          4'd8, 4'd9, 4'd10, 4'd11:  w_row = 8'h66;
          default:                   w_row = 8'h00;
        endcase
      end
      7'h42: begin
        case (w_line)
          4'd2, 4'd6, 4'd11:         w_row = 8'h7C;
          4'd3, 4'd4, 4'd5:          w_row = 8'h66;
          4'd7, 4'd8, 4'd9, 4'd10:   w_row = 8'h66;
          default:                   w_row = 8'h00;
        endcase
      end
      7'h5A: begin
        case (w_line)
          4'd2, 4'd11:               w_row = 8'h7E;
          4'd3:                      w_row = 8'h06;
          4'd4, 4'd5:                w_row = 8'h0C;
          4'd6, 4'd7:                w_row = 8'h18;
          4'd8, 4'd9:                w_row = 8'h30;
          4'd10:                     w_row = 8'h60;
          default:                   w_row = 8'h00;
        endcase
      end
      default: begin
        if (w_code > 7'h20 && w_code < 7'h7F) begin
          case (w_line)
            4'd2, 4'd11:             w_row = 8'h7E;
            4'd3, 4'd4, 4'd5, 4'd6,
            4'd7, 4'd8, 4'd9, 4'd10: w_row = 8'h42;
            default:                 w_row = 8'h00;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    r_data <= w_row;
  end

  assign o_data = r_data;

endmodule

// File: rtl/tft_text_renderer.sv
// 60x17 character-cell text renderer for a 480x272 TFT: byte-stream writer FSM,
// dual-port character buffer and a 3-stage render pipe aligned to the driver scan.
module tft_text_renderer
  import tft_text_renderer_pkg::*;
#(
  parameter logic [23:0] FG_RGB    = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB    = 24'h000020,
  parameter int          BLINK_BIT = 4
) (
  input  logic       tft_clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic       new_frame,
  input  logic [7:0] char_data,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [7:0] out_red,
  output logic [7:0] out_green,
  output logic [7:0] out_blue,
  output logic [5:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       busy
);

  txt_state_e r_state, w_state_nx;
  logic [9:0] r_clr_addr, w_clr_nx;
  logic [5:0] r_col, w_col_nx;
  logic [4:0] r_row, w_row_nx;
  logic [4:0] r_frame;

  logic       w_fire, w_printable, w_bs_ok;
  logic [5:0] w_bs_col;
  logic [4:0] w_bs_row, w_row_inc;
  logic       w_we;
  logic [9:0] w_waddr;
  logic [7:0] w_wdata;

  // Handshake: a byte transfers on a rising edge where char_valid && char_ready;
  // char_ready depends only on state, never on char_valid, and is low throughout CLEAR.
  assign char_ready = (r_state == ST_IDLE);
  assign busy       = (r_state == ST_CLEAR);
  assign w_fire     = char_valid && char_ready;
  assign w_printable = (char_data >= 8'h20) && (char_data <= 8'h7E);

  assign w_row_inc = (r_row == 5'(TXT_ROWS - 1)) ? 5'd0 : r_row + 5'd1;
  assign w_bs_ok   = (r_col != 6'd0) || (r_row != 5'd0);
  assign w_bs_col  = (r_col != 6'd0) ? r_col - 6'd1 : 6'(TXT_COLS - 1);
  assign w_bs_row  = (r_col != 6'd0) ? r_row : r_row - 5'd1;

  always_comb begin
    w_state_nx = r_state;
    w_clr_nx   = r_clr_addr;
    w_col_nx   = r_col;
    w_row_nx   = r_row;
    w_we       = 1'b0;
    w_waddr    = r_clr_addr;
    w_wdata    = ASCII_SP;
    case (r_state)
      ST_CLEAR: begin
        w_we = 1'b1;
        if (r_clr_addr == 10'(TXT_CELLS - 1)) begin
          w_state_nx = ST_IDLE;
          w_clr_nx   = 10'd0;
        end else begin
          w_clr_nx = r_clr_addr + 10'd1;
        end
      end
      default: begin
        if (w_fire) begin
          if (w_printable) begin
            w_we    = 1'b1;
            w_waddr = cell_addr(r_row, {1'b0, r_col});
            w_wdata = char_data;
            if (r_col == 6'(TXT_COLS - 1)) begin
              w_col_nx = 6'd0;
              w_row_nx = w_row_inc;
            end else begin
              w_col_nx = r_col + 6'd1;
            end
          end else begin
            case (char_data)
              ASCII_BS: begin
                if (w_bs_ok) begin
                  w_col_nx = w_bs_col;
                  w_row_nx = w_bs_row;
                  w_we     = 1'b1;
                  w_waddr  = cell_addr(w_bs_row, {1'b0, w_bs_col});
                end
              end
              ASCII_LF: begin
                w_col_nx = 6'd0;
                w_row_nx = w_row_inc;
              end
              ASCII_FF: begin
                w_col_nx   = 6'd0;
                w_row_nx   = 5'd0;
                w_state_nx = ST_CLEAR;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge tft_clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= 10'd0;
      r_col      <= 6'd0;
      r_row      <= 5'd0;
      r_frame    <= 5'd0;
    end else begin
      r_state    <= w_state_nx;
      r_clr_addr <= w_clr_nx;
      r_col      <= w_col_nx;
      r_row      <= w_row_nx;
      if (new_frame) r_frame <= r_frame + 5'd1;
    end
  end

  assign cursor_col = r_col;
  assign cursor_row = r_row;

  // Lookahead coordinate: three pixels ahead of the driver so the registered output lines up.
  logic [10:0] w_xs;
  logic [9:0]  w_xl;
  logic [8:0]  w_yl;
  logic        w_active, w_cur_cell;
  logic [9:0]  w_raddr;

  assign w_xs = {1'b0, x} + 11'd3;

  always_comb begin
    w_xl = w_xs[9:0];
    w_yl = y;
    if (w_xs >= 11'(H_TOTAL)) begin
      w_xl = 10'(w_xs - 11'(H_TOTAL));
      w_yl = (y == 9'(V_TOTAL - 1)) ? 9'd0 : y + 9'd1;
    end
  end

  assign w_active   = (w_xl < 10'(H_ACTIVE)) && (w_yl < 9'(V_ACTIVE));
  assign w_raddr    = cell_addr(w_yl[8:4], w_xl[9:3]);
  assign w_cur_cell = (w_xl[9:3] == {1'b0, r_col}) && (w_yl[8:4] == r_row);

  // Read-first buffer: a same-address read during a write returns the old byte.
  logic [7:0] r_mem [0:1023];
  logic [7:0] r_rd_char;

  always_ff @(posedge tft_clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
    r_rd_char <= r_mem[w_raddr];
  end

  logic       r_s1_active, r_s1_cur;
  logic [3:0] r_s1_line;
  logic [2:0] r_s1_px;
  logic       r_s2_active, r_s2_cur_ul, r_s2_blank;
  logic [2:0] r_s2_px;
  logic [7:0] w_font_row;
  logic       w_bit, w_cur_pix;
  logic [23:0] w_rgb, r_rgb;

  tft_font_rom u_font (
    .i_clk  (tft_clk),
    .i_addr ({r_rd_char[6:0], r_s1_line}),
    .o_data (w_font_row)
  );

  assign w_bit     = w_font_row[3'd7 - r_s2_px] && !r_s2_blank;
  assign w_cur_pix = r_s2_cur_ul && r_frame[BLINK_BIT];
  assign w_rgb     = !r_s2_active          ? 24'h000000 :
                     (w_bit || w_cur_pix) ? FG_RGB     : BG_RGB;

  always_ff @(posedge tft_clk or posedge rst) begin
    if (rst) begin
      r_s1_active <= 1'b0;
      r_s1_cur    <= 1'b0;
      r_s1_line   <= 4'd0;
      r_s1_px     <= 3'd0;
      r_s2_active <= 1'b0;
      r_s2_cur_ul <= 1'b0;
      r_s2_blank  <= 1'b0;
      r_s2_px     <= 3'd0;
      r_rgb       <= 24'h000000;
    end else begin
      r_s1_active <= w_active;
      r_s1_cur    <= w_cur_cell;
      r_s1_line   <= w_yl[3:0];
      r_s1_px     <= w_xl[2:0];
      r_s2_active <= r_s1_active;
      r_s2_cur_ul <= r_s1_cur && (r_s1_line >= 4'd14);
      r_s2_blank  <= r_rd_char[7];
      r_s2_px     <= r_s1_px;
      r_rgb       <= w_rgb;
    end
  end

  assign out_red   = r_rgb[23:16];
  assign out_green = r_rgb[15:8];
  assign out_blue  = r_rgb[7:0];

endmodule
